// File: rtl/uart_pkg.sv
// uart_pkg: UART state encoding, framing constants and baud divider helper
// shared by the receiver and transmitter.
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK = 7;
    localparam int DATA_BITS = 8;

    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud * OVERSAMPLE / 2) / (baud * OVERSAMPLE);
    endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running oversample tick divider with synchronous clear and enable.
module uart_baud_gen #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int W = DIV > 1 ? $clog2(DIV) : 1;

    logic [W-1:0] cnt;

    always_comb tick = en && cnt == W'(DIV - 1);

    always_ff @(posedge clk)
        if (!rst_n || clr) cnt <= '0;
        else if (en) cnt <= tick ? '0 : cnt + W'(1);
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled 8N1 receiver with valid/ready output and error pulses.
// Define UART_RX_PARITY_EN for 8E1 framing with a live oPARITY_ERR.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD = 115_200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       iCLK_50,
    input  logic       iRST_N,
    input  logic       iRXD,
    output logic [7:0] oDATA,
    output logic       oVALID,
    input  logic       iREADY,
    output logic       oFRAME_ERR,
    output logic       oPARITY_ERR,
    output logic       oOVERRUN,
    output logic       oBUSY
);
    localparam int DIV = baud_div(CLK_HZ, BAUD);
    localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
`ifdef UART_RX_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
`else
    localparam state_t AFTER_DATA = STOP;
`endif

    state_t state, state_nx;
    logic rx_meta, rxs;
    logic tick, start_go, mid, bit_end, deliver, stop_bad;
    logic [3:0] tick_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic par_err;

    always_ff @(posedge iCLK_50)
        if (!iRST_N) {rx_meta, rxs} <= 2'b11;
        else {rx_meta, rxs} <= {iRXD, rx_meta};

    uart_baud_gen #(.DIV(DIV)) u_baud (
        .clk(iCLK_50),
        .rst_n(iRST_N),
        .clr(start_go),
        .en(oBUSY),
        .tick(tick)
    );

    always_ff @(posedge iCLK_50)
        if (!iRST_N) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (!rxs) state_nx = START;
            START:   if (mid && rxs) state_nx = IDLE;
                     else if (bit_end) state_nx = DATA;
            DATA:    if (bit_end && bit_cnt == 3'(DATA_BITS - 1)) state_nx = AFTER_DATA;
            PARITY:  if (bit_end) state_nx = STOP;
            STOP:    if (mid) state_nx = rxs ? IDLE : BREAK;
            BREAK:   if (rxs) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // STOP leaves at mid-bit so a back-to-back start edge is not missed
    always_comb begin
        oBUSY = state != IDLE;
        start_go = state == IDLE && !rxs;
        mid = tick && tick_cnt == 4'(MID_TICK);
        bit_end = tick && tick_cnt == LAST_TICK;
        deliver = state == STOP && mid && rxs && !par_err;
        stop_bad = state == STOP && mid && !rxs;
    end

    always_ff @(posedge iCLK_50)
        if (!iRST_N || start_go) begin
            tick_cnt <= '0;
            bit_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= tick_cnt + 4'd1;
            if (state == DATA && bit_end) bit_cnt <= bit_cnt + 3'd1;
        end

    always_ff @(posedge iCLK_50)
        if (!iRST_N) shreg <= '0;
        else if (state == DATA && mid) shreg <= {rxs, shreg[7:1]};

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge iCLK_50)
        if (!iRST_N || start_go) par_err <= 1'b0;
        else if (state == PARITY && mid) par_err <= rxs != ^shreg;

    always_ff @(posedge iCLK_50)
        if (!iRST_N) oPARITY_ERR <= 1'b0;
        else oPARITY_ERR <= state == STOP && mid && rxs && par_err;
`else
    always_comb begin
        par_err = 1'b0;
        oPARITY_ERR = 1'b0;
    end
`endif

    // a byte landing on the same edge the old one is accepted is not an overrun
    always_ff @(posedge iCLK_50)
        if (!iRST_N) begin
            oDATA <= '0;
            oVALID <= 1'b0;
            oFRAME_ERR <= 1'b0;
            oOVERRUN <= 1'b0;
        end else begin
            oFRAME_ERR <= stop_bad;
            oOVERRUN <= deliver && oVALID && !iREADY;
            if (deliver && (!oVALID || iREADY)) begin
                oDATA <= shreg;
                oVALID <= 1'b1;
            end else if (iREADY) oVALID <= 1'b0;
        end
endmodule
